// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch/decode constants and the fetch entry type
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries; clear beats push, pop frees a slot for a same-cycle push
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, credit-limited imem requests, instruction buffer, decode register
module fetch_stage
  import fetch_stage_pkg::XLEN, fetch_stage_pkg::fetch_entry_t;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR  = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCplus4D,
  output logic            ValidD
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  pc_f_q, pc_f_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0]  instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic             valid_q, valid_d;

  logic             req_hs, rsp_drop, rsp_accept, dec_pop, credit_ok;
  fetch_entry_t     inst_head, inst_push_data, pcq_head, pcq_push_data;
  logic             inst_full, inst_empty, pcq_full, pcq_empty;
  logic [CNT_W-1:0] inst_count, pcq_count;

  // Responses still owed by memory count against the buffer, so a grant always finds a slot.
  assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, inst_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign imem_req_valid = !rst && !PCSrcE && credit_ok;
  assign imem_req_addr  = pc_f_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_accept     = imem_rsp_valid && (drop_cnt_q == '0) && !PCSrcE;
  assign dec_pop        = !FlushD && !StallD && !inst_empty;

  assign pcq_push_data = '{instr: NOP_INSTR, pc: pc_f_q};

  always_comb begin
    inst_push_data       = pcq_head;
    inst_push_data.instr = imem_rsp_data;
  end

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_pc_queue (
    .clk(clk), .rst(rst), .push(req_hs), .push_data(pcq_push_data), .pop(rsp_accept),
    .clear(PCSrcE), .head(pcq_head), .full(pcq_full), .empty(pcq_empty), .count(pcq_count)
  );

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_inst_fifo (
    .clk(clk), .rst(rst), .push(rsp_accept), .push_data(inst_push_data), .pop(dec_pop),
    .clear(PCSrcE), .head(inst_head), .full(inst_full), .empty(inst_empty), .count(inst_count)
  );

  always_comb begin
    pc_f_d        = pc_f_q;
    outstanding_d = outstanding_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (PCSrcE) begin
      // Everything memory still owes after this cycle's response belongs to the wrong path.
      pc_f_d     = {PCTargetE[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_hs)   pc_f_d     = pc_f_q + XLEN'(4);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    if (FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!StallD) begin
      if (!inst_empty) begin
        valid_d = 1'b1;
        instr_d = inst_head.instr;
        pcd_d   = inst_head.pc;
        pcp4_d  = inst_head.pc + XLEN'(4);
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      pcd_q         <= '0;
      pcp4_q        <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pcd_q         <= pcd_d;
      pcp4_q        <= pcp4_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCplus4D = pcp4_q;
  assign ValidD   = valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && outstanding_q == '0))
        else $error("fetch_stage: response with nothing outstanding");
      assert (!(rsp_accept && inst_full && !dec_pop))
        else $error("fetch_stage: instruction buffer overflow");
      assert (!(req_hs && pcq_full))
        else $error("fetch_stage: pc queue overflow");
      assert (!(rsp_accept && pcq_empty))
        else $error("fetch_stage: accepted response without a pc");
      assert (pcq_count <= outstanding_q)
        else $error("fetch_stage: pc queue larger than outstanding");
    end
  end
endmodule
